core_router: RTL and testbench
==============================

Name: core_router

Overview:
- Runtime selector for the DSP core that drives the calibrated outputs. Replaces compile-time core selection.
- All instantiated cores run in parallel on the calibrated inputs. This block picks one core's output set to forward to the output calibration stage.
- Switching is triggered by a debounced button press. Each switch uses a linear crossfade over a fixed number of sample periods, so switching is click-free.

Parameters:
- W, 16: sample width, bits, signed two's complement.
- N_CH, 4: channels per core.
- N_CORES, 4: number of selectable cores, >=2.
- XFADE_LOG2, 8: crossfade length is 2^XFADE_LOG2 sample periods.
- DEBOUNCE_CYCLES, 120000: number of clk cycles the button must be stable before a level is accepted (10 ms at 12 MHz).

Ports:
- clk, in, 1: system clock (12 MHz).
- rst, in, 1: synchronous reset, active-high.
- sample_clk, in, 1: single-cycle strobe, one per audio sample, in the clk domain.
- btn_n, in, 1: raw button, active-low, asynchronous to clk.
- cv_in, in, W: signed control sample. Used only with CORE_ROUTER_CV_SELECT_EN.
- core_out, in, N_CORES*N_CH*W: flattened core outputs. Core c, channel k occupies bits [(c*N_CH+k)*W +: W].
- sample_out, out, N_CH*W: routed/crossfaded outputs. Channel k occupies bits [k*W +: W].
- active_core, out, $clog2(N_CORES): index of the core currently fully selected.
- xfade_busy, out, 1: high while a crossfade is in progress.

Behaviour:
- Reset values: sample_out=0, active_core=0, xfade_busy=0, gain=0, pending=0, FSM=IDLE, debounced level=1 (released).
- Button path:
  - btn_n passes through a 2-flop synchroniser, then a debounce counter.
  - The counter reloads on any change of the synchronised level. The new level is accepted when DEBOUNCE_CYCLES consecutive stable cycles elapse.
  - A press event is a 1->0 transition of the debounced level, one cycle wide.
- FSM state IDLE:
  - sample_out[k] = core_out[active_core][k], registered on the cycle after sample_clk.
  - On a press event (or pending=1): target = (active_core+1) mod N_CORES (wraps N_CORES-1 -> 0); gain=0; pending=0; go to FADE.
- FSM state FADE:
  - xfade_busy=1.
  - On each sample_clk: out = (a*(2^X - g) + b*g) >>> X, where X=XFADE_LOG2, a is the active_core sample, b is the target sample, g is the gain. Then g increments.
  - Gain is unsigned, X+1 bits. Products are signed, W+X+2 bits.
  - Arithmetic shift truncates toward -inf. No saturation is needed, because the result is a convex combination.
  - When g reaches 2^X: active_core<=target, xfade_busy<=0, go to IDLE. That sample is output as pure b.
- Latency: sample_out updates exactly 1 clk after sample_clk and holds between strobes. Without a sample_clk strobe, neither output nor gain changes.
- Press during FADE: latches pending=1 (depth 1; further presses dropped). A new fade starts from IDLE on the next cycle after completion.
- Press event and sample_clk in the same cycle in IDLE: that sample is output as the pure active core, and the fade starts from the next strobe.
- Reset mid-fade: immediately back to IDLE with active_core=0. Pending is cleared.

Optional Feature:
- Macro: CORE_ROUTER_CV_SELECT_EN.
- Enabled:
  - On each sample_clk, cv_in is quantised to a zone: zone = (cv_in + 2^(W-1)) * N_CORES >> W, an unsigned index.
  - If the same zone differs from active_core for 4 consecutive samples while in IDLE, a fade to that zone starts.
  - Button presses still advance target as above.
  - A CV request arriving during FADE is ignored. It is re-evaluated after the fade completes.
- Disabled: cv_in is unused, and selection is by button only.

Decomposition:
- Package core_router_pkg:
  - FSM enum {IDLE, FADE}.
  - Function computing the flattened slice base.
  - Localparam CV_STABLE_SAMPLES=4.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES): synchroniser, counter, debounced level, press pulse. Reused for other panel buttons.
- The crossfade datapath is generated per channel inline.

Test Plan:
Bench settings: N_CORES=4, N_CH=4, W=16, XFADE_LOG2=2, DEBOUNCE_CYCLES=16. Core c, channel k is held at constant 1000*c+k.
- Reset, strobe sample_clk -> sample_out ch0..3 = 0,1,2,3 one clk after the strobe; active_core=0; xfade_busy=0.
- Single clean press held 20 cycles, then 4 strobes:
  - ch0 sequence 0, 250, 500, 750 (g=0..3).
  - 5th strobe gives 1000, active_core=1, xfade_busy=0.
- Bounce: btn_n toggles every 5 cycles for 60 cycles, then stays high -> no press event, active_core unchanged.
- Three presses from active_core=3, with a fade completing between each -> wraps to 0, then 1, then 2.
- Two presses during one fade -> exactly one extra fade follows; final active_core=2 from 0.
- Signed check: core0 = -32768, core1 = 32767, XFADE_LOG2=2 -> ch0 sequence -32768, -16385, -1, 16383, then 32767. No overflow.

Source files
------------

// File: rtl/core_router_pkg.sv
// core_router shared types and helpers.
package core_router_pkg;

  typedef enum logic {
    IDLE,
    FADE
  } state_e;

  localparam int CV_STABLE_SAMPLES = 4;

  function automatic int slice_base(
    input int c,
    input int k,
    input int n_ch,
    input int w
  );
    return (c * n_ch + k) * w;
  endfunction

endpackage

// File: rtl/core_router_btn_debounce.sv
// Button synchroniser + debouncer with one-cycle press pulse.
// Reusable for any active-low panel button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while sync disagrees with the accepted level,
  // so any flip of the synchronised input reloads it.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/core_router.sv
// Runtime DSP core selector with click-free linear crossfade.
// Optional CV zone selection: CORE_ROUTER_CV_SELECT_EN.
module core_router
  import core_router_pkg::*;
#(
  parameter int W               = 16,
  parameter int N_CH            = 4,
  parameter int N_CORES         = 4,
  parameter int XFADE_LOG2      = 8,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_clk,
  input  logic                      btn_n,
  input  logic [W-1:0]              cv_in,
  input  logic [N_CORES*N_CH*W-1:0] core_out,
  output logic [N_CH*W-1:0]         sample_out,
  output logic [$clog2(N_CORES)-1:0] active_core,
  output logic                      xfade_busy
);

  localparam int AW = $clog2(N_CORES);
  localparam int X  = XFADE_LOG2;
  localparam int P  = W + X + 2;
  localparam logic [X:0] G_ONE = (X+1)'(1) << X;

  state_e              state_q, state_d;
  logic [AW-1:0]       active_q, active_d;
  logic [AW-1:0]       target_q, target_d;
  logic [X:0]          gain_q, gain_d;
  logic                pending_q, pending_d;
  logic [N_CH*W-1:0]   sout_q, sout_d;

  logic                press;
  logic                btn_level;
  logic                cv_req;
  logic [AW-1:0]       cv_target;
  logic [AW-1:0]       next_core;

  logic [W-1:0]        core_s [N_CORES][N_CH];
  logic [N_CH*W-1:0]   pure_a;
  logic [N_CH*W-1:0]   mix;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn_n(btn_n),
    .level(btn_level),
    .press(press)
  );

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign core_s[c][k] = core_out[slice_base(c, k, N_CH, W) +: W];
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_mix
    logic signed [P-1:0] pa, pb, wa, wb, sum, sh;
    assign pa  = P'($signed(core_s[active_q][k]));
    assign pb  = P'($signed(core_s[target_q][k]));
    assign wa  = $signed(P'(G_ONE - gain_q));
    assign wb  = $signed(P'(gain_q));
    assign sum = pa * wa + pb * wb;
    assign sh  = sum >>> X;
    assign mix[k*W +: W]    = sh[W-1:0];
    assign pure_a[k*W +: W] = core_s[active_q][k];
  end

  assign next_core = (active_q == AW'(N_CORES - 1)) ? '0
                   : active_q + 1'b1;

`ifdef CORE_ROUTER_CV_SELECT_EN
  localparam int PW = W + AW + 1;
  localparam int SW = 3;

  logic [W-1:0]  cv_off;
  logic [PW-1:0] cv_prod;
  logic [AW-1:0] cv_zone;
  logic [AW-1:0] cv_zone_q, cv_zone_d;
  logic [SW-1:0] cv_cnt_q, cv_cnt_d;

  assign cv_off  = {~cv_in[W-1], cv_in[W-2:0]};
  assign cv_prod = PW'(cv_off) * PW'(N_CORES);
  assign cv_zone = AW'(cv_prod >> W);

  // Counter is cleared while fading so a request is re-evaluated afterwards.
  always_comb begin
    cv_cnt_d  = cv_cnt_q;
    cv_zone_d = cv_zone_q;
    if (state_q != IDLE) begin
      cv_cnt_d = '0;
    end else if (sample_clk) begin
      cv_zone_d = cv_zone;
      if (cv_zone == active_q) begin
        cv_cnt_d = '0;
      end else if (cv_zone == cv_zone_q && cv_cnt_q != '0) begin
        if (cv_cnt_q < SW'(CV_STABLE_SAMPLES))
          cv_cnt_d = cv_cnt_q + 1'b1;
      end else begin
        cv_cnt_d = SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cv_zone_q <= '0;
      cv_cnt_q  <= '0;
    end else begin
      cv_zone_q <= cv_zone_d;
      cv_cnt_q  <= cv_cnt_d;
    end
  end

  assign cv_req    = (state_q == IDLE) &&
                     (cv_cnt_q >= SW'(CV_STABLE_SAMPLES));
  assign cv_target = cv_zone_q;
`else
  logic unused_cv;
  assign unused_cv = ^cv_in;
  assign cv_req    = 1'b0;
  assign cv_target = '0;
`endif

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    target_d  = target_q;
    gain_d    = gain_q;
    pending_d = pending_q;
    sout_d    = sout_q;
    unique case (state_q)
      IDLE: begin
        if (sample_clk)
          sout_d = pure_a;
        if (press || pending_q) begin
          target_d  = next_core;
          gain_d    = '0;
          pending_d = 1'b0;
          state_d   = FADE;
        end else if (cv_req) begin
          target_d = cv_target;
          gain_d   = '0;
          state_d  = FADE;
        end
      end
      FADE: begin
        if (press)
          pending_d = 1'b1;
        if (sample_clk) begin
          sout_d = mix;
          if (gain_q == G_ONE) begin
            active_d = target_q;
            state_d  = IDLE;
          end else begin
            gain_d = gain_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      active_q  <= '0;
      target_q  <= '0;
      gain_q    <= '0;
      pending_q <= 1'b0;
      sout_q    <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      target_q  <= target_d;
      gain_q    <= gain_d;
      pending_q <= pending_d;
      sout_q    <= sout_d;
    end
  end

  assign sample_out  = sout_q;
  assign active_core = active_q;
  assign xfade_busy  = (state_q == FADE);

endmodule

// File: tb/tb_core_router.sv
// Directed bench for core_router with short crossfade and debounce.
module tb_core_router;

  localparam int W = 16;
  localparam int N_CH = 4;
  localparam int N_CORES = 4;
  localparam int XL = 2;
  localparam int DB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_clk = 1'b0;
  logic btn_n = 1'b1;
  logic [W-1:0] cv_in = '0;
  logic [N_CORES*N_CH*W-1:0] core_out;
  logic [N_CH*W-1:0] sample_out;
  logic [1:0] active_core;
  logic xfade_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_router #(
    .W(W), .N_CH(N_CH), .N_CORES(N_CORES),
    .XFADE_LOG2(XL), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .btn_n(btn_n), .cv_in(cv_in), .core_out(core_out),
    .sample_out(sample_out), .active_core(active_core),
    .xfade_busy(xfade_busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ch(input int k);
    logic signed [W-1:0] v;
    v = sample_out[k*W +: W];
    return int'(v);
  endfunction

  task automatic load_cores();
    for (int c = 0; c < N_CORES; c++)
      for (int k = 0; k < N_CH; k++)
        core_out[(c*N_CH+k)*W +: W] = W'(1000*c + k);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe();
    sample_clk = 1'b1;
    @(negedge clk);
    sample_clk = 1'b0;
  endtask

  task automatic press_btn();
    btn_n = 1'b0;
    repeat (20) @(negedge clk);
    btn_n = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  task automatic full_fade();
    press_btn();
    repeat (5) begin
      strobe();
      repeat (2) @(negedge clk);
    end
  endtask

  int exp_seq [5];
  logic signed [W-1:0] tmp;

  initial begin
    load_cores();
    do_reset();

    check("rst_out0", ch(0), 0);
    check("rst_active", int'(active_core), 0);
    check("rst_busy", int'(xfade_busy), 0);
    strobe();
    for (int k = 0; k < N_CH; k++)
      check($sformatf("idle_ch%0d", k), ch(k), k);

    press_btn();
    check("fade_busy", int'(xfade_busy), 1);
    exp_seq = '{0, 250, 500, 750, 1000};
    for (int i = 0; i < 5; i++) begin
      strobe();
      check($sformatf("fade_s%0d", i), ch(0), exp_seq[i]);
      repeat (3) @(negedge clk);
      if (i < 4) check($sformatf("hold_s%0d", i), ch(0), exp_seq[i]);
    end
    check("fade_ch3", ch(3), 1003);
    check("fade_active", int'(active_core), 1);
    check("fade_done_busy", int'(xfade_busy), 0);

    for (int i = 0; i < 12; i++) begin
      btn_n = ~btn_n;
      repeat (5) @(negedge clk);
    end
    btn_n = 1'b1;
    repeat (40) @(negedge clk);
    check("bounce_active", int'(active_core), 1);
    check("bounce_busy", int'(xfade_busy), 0);

    full_fade();
    full_fade();
    check("to3_active", int'(active_core), 3);
    full_fade();
    check("wrap0", int'(active_core), 0);
    full_fade();
    check("wrap1", int'(active_core), 1);
    full_fade();
    check("wrap2", int'(active_core), 2);

    do_reset();
    press_btn();
    strobe();
    strobe();
    press_btn();
    press_btn();
    check("pend_busy", int'(xfade_busy), 1);
    repeat (3) strobe();
    check("pend_first_active", int'(active_core), 1);
    repeat (3) @(negedge clk);
    check("pend_refade_busy", int'(xfade_busy), 1);
    repeat (5) strobe();
    check("pend_final_active", int'(active_core), 2);
    check("pend_final_busy", int'(xfade_busy), 0);
    strobe();
    check("pend_ch0", ch(0), 2000);
    repeat (10) @(negedge clk);
    check("pend_no_extra", int'(xfade_busy), 0);

    do_reset();
    tmp = -16'sd32768;
    core_out[0 +: W] = tmp;
    tmp = 16'sd32767;
    core_out[(1*N_CH)*W +: W] = tmp;
    press_btn();
    exp_seq = '{-32768, -16385, -1, 16383, 32767};
    for (int i = 0; i < 5; i++) begin
      strobe();
      check($sformatf("signed_s%0d", i), ch(0), exp_seq[i]);
      @(negedge clk);
    end
    check("signed_active", int'(active_core), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
